// File: rtl/temp_sample_scheduler_if.sv
// Bundle between the temperature sample scheduler, the sensor front-end and the
// sum/average accumulator. The scheduler side uses the master modport.
interface temp_sample_scheduler_if #(
  parameter int N_CH = 4
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  // Handshake: conv_req is a one-cycle request for channel conv_ch; the front-end
  // answers later with a one-cycle conv_done carrying conv_data, which is only
  // honoured while the scheduler waits for it. smp_valid is a one-cycle strobe
  // with no back-pressure: the accumulator must take smp_ch/smp_data that cycle.
  logic            enable;
  logic            conv_req;
  logic [CH_W-1:0] conv_ch;
  logic            conv_done;
  logic [8:0]      conv_data;
  logic            smp_valid;
  logic [CH_W-1:0] smp_ch;
  logic [8:0]      smp_data;
  logic            win_start;
  logic            win_done;
  logic            sec_tick;
  logic [5:0]      sec_cnt;
  logic            busy;
  logic            ovr;
  logic            err;
  logic [2:0]      dbg_state;

  modport master (
    input  enable, conv_done, conv_data,
    output conv_req, conv_ch, smp_valid, smp_ch, smp_data, win_start, win_done,
           sec_tick, sec_cnt, busy, ovr, err, dbg_state
  );

  modport slave (
    output enable, conv_done, conv_data,
    input  conv_req, conv_ch, smp_valid, smp_ch, smp_data, win_start, win_done,
           sec_tick, sec_cnt, busy, ovr, err, dbg_state
  );
endinterface

// File: rtl/temp_sample_scheduler.sv
// Temperature acquisition sequencer: 1 s tick, round-robin channel sweep with the
// sensor front-end, sample strobes and averaging-window framing.
// Optional WAIT timeout with last-good substitution: define TEMP_SCHED_TIMEOUT_EN.
module temp_sample_scheduler #(
  parameter int CLK_HZ          = 50000000,
  parameter int N_CH            = 4,
  parameter int SAMPLES_PER_WIN = 60,
  parameter int TIMEOUT_CYC     = 1000
) (
  input logic                      clk,
  input logic                      rst,
  temp_sample_scheduler_if.master  bus
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [TW-1:0]   TICK_LAST = TW'(CLK_HZ - 1);
  localparam logic [CH_W-1:0] CH_LAST   = CH_W'(N_CH - 1);
  localparam logic [5:0]      WIN_LAST  = 6'(SAMPLES_PER_WIN - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_EMIT = 3'd3,
    S_NEXT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_cnt_q;
  logic            sec_tick_q;
  logic            pending_q;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [5:0]      sec_cnt_q, sec_cnt_d;
  logic [8:0]      smp_data_q, smp_data_d;

  logic            idle;
  logic            start;
  logic            tick_defer;
  logic            tick_drop;
  logic            sweep_last;
  logic            win_last;

  // Second tick generator; disabling holds the phase at zero.
  always_ff @(posedge clk) begin
    if (rst || !bus.enable) begin
      tick_cnt_q <= '0;
      sec_tick_q <= 1'b0;
    end else if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_q <= '0;
      sec_tick_q <= 1'b1;
    end else begin
      tick_cnt_q <= tick_cnt_q + TW'(1);
      sec_tick_q <= 1'b0;
    end
  end

  assign idle       = (state_q == S_IDLE);
  assign start      = idle && bus.enable && (sec_tick_q || pending_q);
  assign tick_defer = sec_tick_q && !idle && !pending_q;
  assign tick_drop  = sec_tick_q && !idle && pending_q;
  assign sweep_last = (ch_q == CH_LAST);
  assign win_last   = (sec_cnt_q == WIN_LAST);

  // At most one tick is remembered while a sweep is still running.
  always_ff @(posedge clk) begin
    if (rst || !bus.enable) begin
      pending_q <= 1'b0;
    end else if (start) begin
      pending_q <= 1'b0;
    end else if (tick_defer) begin
      pending_q <= 1'b1;
    end
  end

`ifdef TEMP_SCHED_TIMEOUT_EN
  localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYC - 1);

  logic [WW-1:0] wait_cnt_q;
  logic [8:0]    hold_q [N_CH];
  logic          err_q;
  logic          timed_out;

  // REQ is the only way into WAIT, so clearing there restarts the count per request.
  always_ff @(posedge clk) begin
    if (rst || state_q == S_REQ) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_WAIT) begin
      wait_cnt_q <= wait_cnt_q + WW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        hold_q[i] <= '0;
      end
    end else if (state_q == S_WAIT && bus.conv_done) begin
      hold_q[ch_q] <= bus.conv_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (timed_out) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      sec_cnt_q  <= '0;
      smp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      sec_cnt_q  <= sec_cnt_d;
      smp_data_q <= smp_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    sec_cnt_d  = sec_cnt_q;
    smp_data_d = smp_data_q;
`ifdef TEMP_SCHED_TIMEOUT_EN
    timed_out  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ch_d    = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.conv_done) begin
          smp_data_d = bus.conv_data;
          state_d    = S_EMIT;
        end
`ifdef TEMP_SCHED_TIMEOUT_EN
        else if (wait_cnt_q == WAIT_LAST) begin
          // Silent channel: re-issue its last good reading and flag the fault.
          smp_data_d = hold_q[ch_q];
          timed_out  = 1'b1;
          state_d    = S_EMIT;
        end
`endif
      end
      S_EMIT: begin
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (!sweep_last) begin
          ch_d    = ch_q + CH_W'(1);
          state_d = S_REQ;
        end else begin
          sec_cnt_d = win_last ? 6'd0 : sec_cnt_q + 6'd1;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.conv_req  = (state_q == S_REQ);
  assign bus.conv_ch   = ch_q;
  assign bus.smp_valid = (state_q == S_EMIT);
  assign bus.smp_ch    = ch_q;
  assign bus.smp_data  = smp_data_q;
  assign bus.win_start = (state_q == S_EMIT) && (ch_q == '0) && (sec_cnt_q == 6'd0);
  assign bus.win_done  = (state_q == S_NEXT) && sweep_last && win_last;
  assign bus.sec_tick  = sec_tick_q;
  assign bus.sec_cnt   = sec_cnt_q;
  assign bus.busy      = !idle;
  assign bus.ovr       = tick_drop && bus.enable;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_temp_sample_scheduler.sv
// Self-checking bench for temp_sample_scheduler: sensor responder, scoreboard of
// expected samples and window framing, directed scenarios for ticks, overrun and reset.
module tb_temp_sample_scheduler;

  localparam int CLK_HZ  = 10;
  localparam int N_CH    = 2;
  localparam int SPW     = 3;
  localparam int TIMEOUT = 5;
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int W       = CH_W + 9;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd2;

  logic clk;
  logic rst;
  logic enable;
  logic resp_done, inj_done;
  logic [8:0] resp_data, inj_data;

  temp_sample_scheduler_if #(.N_CH(N_CH)) bus ();

  temp_sample_scheduler #(
    .CLK_HZ(CLK_HZ), .N_CH(N_CH), .SAMPLES_PER_WIN(SPW), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  assign bus.enable    = enable;
  assign bus.conv_done = resp_done | inj_done;
  assign bus.conv_data = resp_done ? resp_data : inj_data;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // sensor responder controls
  logic            sens_en;
  int              sens_lat;
  logic            sens_fixed;
  logic [8:0]      sens_fix_data;
  logic            mute_en;
  logic [CH_W-1:0] mute_ch;

  logic [W-1:0]    exp_q[$];
  logic [8:0]      last_good [N_CH];
  logic [CH_W-1:0] exp_req_ch;
  logic [CH_W-1:0] resp_ch;
  logic            resp_busy;
  int              resp_cnt;

  always begin
    @(posedge clk); #1;
    resp_done = 1'b0;
    if (rst) begin
      resp_busy  = 1'b0;
      resp_cnt   = 0;
      exp_req_ch = '0;
      for (int i = 0; i < N_CH; i++) last_good[i] = '0;
    end else begin
      if (resp_busy) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          resp_busy = 1'b0;
          resp_done = 1'b1;
          resp_data = sens_fixed ? sens_fix_data : 9'($urandom_range(0, 511));
          last_good[resp_ch] = resp_data;
          exp_q.push_back({resp_ch, resp_data});
        end
      end
      if (bus.conv_req) begin
        check("conv_ch", 32'(bus.conv_ch), 32'(exp_req_ch));
        exp_req_ch = (exp_req_ch == CH_W'(N_CH - 1)) ? '0 : exp_req_ch + CH_W'(1);
        if (mute_en && bus.conv_ch == mute_ch) begin
`ifdef TEMP_SCHED_TIMEOUT_EN
          exp_q.push_back({bus.conv_ch, last_good[bus.conv_ch]});
`endif
        end else if (sens_en) begin
          resp_busy = 1'b1;
          resp_cnt  = sens_lat;
          resp_ch   = bus.conv_ch;
        end
      end
    end
  end

  // scoreboard / monitor
  int   m_sec, smp_cnt, ws_cnt, wd_cnt, ovr_cnt;
  logic pend_close;

  always begin
    logic [W-1:0] e;
    logic         have_e, exp_wd, exp_ws;
    @(posedge clk); #1;
    if (rst) begin
      exp_q.delete();
      m_sec = 0; pend_close = 1'b0;
      smp_cnt = 0; ws_cnt = 0; wd_cnt = 0; ovr_cnt = 0;
    end else begin
      exp_wd = pend_close && (m_sec == SPW - 1);
      if (bus.win_done || exp_wd) check("win_done", 32'(bus.win_done), 32'(exp_wd));
      if (bus.win_done) wd_cnt++;
      if (pend_close) begin
        m_sec = (m_sec == SPW - 1) ? 0 : m_sec + 1;
        pend_close = 1'b0;
      end
      have_e = 1'b0;
      exp_ws = 1'b0;
      if (bus.smp_valid) begin
        smp_cnt++;
        check("smp_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          have_e = 1'b1;
          check("smp", 32'({bus.smp_ch, bus.smp_data}), 32'(e));
          check("sec_cnt_at_smp", 32'(bus.sec_cnt), 32'(m_sec));
          exp_ws = (e[W-1:9] == '0) && (m_sec == 0);
          if (e[W-1:9] == CH_W'(N_CH - 1)) pend_close = 1'b1;
        end
      end
      if (bus.win_start || have_e) check("win_start", 32'(bus.win_start), 32'(exp_ws));
      if (bus.win_start) ws_cnt++;
      if (bus.ovr) ovr_cnt++;
    end
  end

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Expects to be called at the negedge of the first cycle after reset.
  task automatic first_sweep(input string tag);
    int cyc = 0;
    int tick_cyc = -1;
    int req_cyc;
    sens_en = 1'b1; sens_lat = 2; sens_fixed = 1'b1; sens_fix_data = 9'h019; mute_en = 1'b0;
    enable = 1'b1;
    while (!bus.conv_req && cyc < 40) begin
      @(negedge clk); cyc++;
      if (bus.sec_tick && tick_cyc < 0) tick_cyc = cyc;
    end
    check({tag, "_tick_cyc"}, 32'(tick_cyc), 32'd10);
    check({tag, "_req_cyc"}, 32'(cyc), 32'd11);
    req_cyc = cyc;
    while (!bus.smp_valid && cyc < 60) begin @(negedge clk); cyc++; end
    check({tag, "_smp_lat"}, 32'(cyc - req_cyc), 32'd3);
    while (cyc < 21) begin @(negedge clk); cyc++; end
    check({tag, "_sec_cnt"}, 32'(bus.sec_cnt), 32'd1);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    check({tag, "_smp_cnt"}, 32'(smp_cnt), 32'd2);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_no_restart"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int k;
    rst = 1'b1; enable = 1'b0;
    inj_done = 1'b0; inj_data = '0;
    sens_en = 1'b1; sens_lat = 2; sens_fixed = 1'b0; sens_fix_data = '0;
    mute_en = 1'b0; mute_ch = '0;
    @(negedge clk);

    // 1: reset state and a single sweep
    do_reset();
    check("reset_outs", 32'({bus.conv_req, bus.smp_valid, bus.win_start, bus.win_done,
                             bus.sec_tick, bus.sec_cnt, bus.busy, bus.ovr, bus.err,
                             bus.smp_data, bus.conv_ch, bus.dbg_state}), 32'd0);
    first_sweep("t1");

    // 2: two full windows, random data
    do_reset();
    sens_lat = 1; sens_fixed = 1'b0; enable = 1'b1;
    k = 0;
    while (wd_cnt < 2 && k < 300) begin @(negedge clk); k++; end
    check("t2_win_done_cnt", 32'(wd_cnt), 32'd2);
    check("t2_win_start_cnt", 32'(ws_cnt), 32'd2);
    check("t2_smp_cnt", 32'(smp_cnt), 32'(2 * SPW * N_CH));
    @(negedge clk);
    check("t2_sec_cnt_wrap", 32'(bus.sec_cnt), 32'd0);
    check("t2_no_ovr", 32'(ovr_cnt), 32'd0);
    enable = 1'b0;

    // 3: slow sensor, pending tick and overrun
    do_reset();
    sens_lat = 12; enable = 1'b1;
    k = 0;
    while (smp_cnt < 2 && k < 80) begin @(negedge clk); k++; end
    check("t3_first_sweep_end", 32'(k), 32'd39);
    check("t3_ovr_once", 32'(ovr_cnt), 32'd1);
    k = 0;
    while (!bus.conv_req && k < 10) begin @(negedge clk); k++; end
    check("t3_restart_gap", 32'(k), 32'd3);
    enable = 1'b0;
    k = 0;
    while (bus.busy && k < 80) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    check("t3_drained", 32'(bus.busy), 32'd0);
    check("t3_smp_cnt", 32'(smp_cnt), 32'd4);
    check("t3_sec_cnt", 32'(bus.sec_cnt), 32'd2);
    check("t3_ovr_total", 32'(ovr_cnt), 32'd2);

    // 4: conv_done outside WAIT is ignored
    do_reset();
    sens_en = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clk);
    inj_done = 1'b1; inj_data = 9'h1FF;
    repeat (2) @(negedge clk);
    inj_done = 1'b0;
    check("t4_idle_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    k = 0;
    while (!bus.conv_req && k < 20) begin @(negedge clk); k++; end
    inj_done = 1'b1; inj_data = 9'h1FF;
    @(negedge clk);
    inj_done = 1'b0;
    check("t4_req_ignored", 32'(bus.dbg_state), 32'(ST_WAIT));
    repeat (3) @(negedge clk);
    check("t4_wait_holds", 32'(bus.dbg_state), 32'(ST_WAIT));
    check("t4_no_smp", 32'(smp_cnt), 32'd0);
    exp_q.push_back({CH_W'(0), 9'h0A5});
    inj_done = 1'b1; inj_data = 9'h0A5;
    sens_en = 1'b1; sens_lat = 2; enable = 1'b0;
    @(negedge clk);
    inj_done = 1'b0;
    k = 0;
    while (bus.busy && k < 40) begin @(negedge clk); k++; end
    check("t4_smp_cnt", 32'(smp_cnt), 32'd2);

    // 5: silent channel
    do_reset();
    sens_lat = 2; sens_fixed = 1'b1; sens_fix_data = 9'h105; enable = 1'b1;
    k = 0;
    while (smp_cnt < 2 && k < 60) begin @(negedge clk); k++; end
    mute_ch = CH_W'(1); mute_en = 1'b1;
    k = 0;
    while (!(bus.conv_req && bus.conv_ch == CH_W'(1)) && k < 40) begin @(negedge clk); k++; end
`ifdef TEMP_SCHED_TIMEOUT_EN
    k = 0;
    while (!bus.smp_valid && k < 20) begin @(negedge clk); k++; end
    check("t5_timeout_lat", 32'(k), 32'(TIMEOUT + 1));
    check("t5_hold_data", 32'(bus.smp_data), 32'h105);
    check("t5_err_set", 32'(bus.err), 32'd1);
    repeat (5) @(negedge clk);
    check("t5_err_sticky", 32'(bus.err), 32'd1);
`else
    repeat (30) @(negedge clk);
    check("t5_stuck_busy", 32'(bus.busy), 32'd1);
    check("t5_stuck_wait", 32'(bus.dbg_state), 32'(ST_WAIT));
    check("t5_no_err", 32'(bus.err), 32'd0);
    check("t5_smp_cnt", 32'(smp_cnt), 32'd3);
`endif

    // 6: reset while waiting, then a clean restart
    k = 0;
    while (bus.dbg_state != ST_WAIT && k < 40) begin @(negedge clk); k++; end
    check("t6_in_wait", 32'(bus.dbg_state), 32'(ST_WAIT));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mute_en = 1'b0;
    check("t6_after_rst", 32'({bus.busy, bus.conv_req, bus.sec_cnt, bus.err, bus.smp_valid}), 32'd0);
    first_sweep("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
